audio_playback_controller: RTL
==============================

AUDIO_PLAYBACK_CONTROLLER -- requirements
Module: audio_playback_controller

Interface
REQ-001 Parameter SAMPLE_DIV, default 12500, clk cycles per audio sample (8 kHz at 100 MHz); legal range 4..2^16.
REQ-002 Parameter ADDR_W, default 24, flash byte-address width.
REQ-003 clk  in  1  system clock; all logic on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 play  in  1  one-cycle start pulse.
REQ-006 stop  in  1  one-cycle abort pulse.
REQ-007 pause  in  1  level; high freezes sample pacing.
REQ-008 loop_en  in  1  level; sampled at end of clip.
REQ-009 start_addr, end_addr  in  ADDR_W each  clip bounds, inclusive; latched on accepted play.
REQ-010 rd_req  out  1  read request to flash byte reader.
REQ-011 rd_addr  out  ADDR_W  byte address, stable while rd_req high.
REQ-012 rd_done  in  1  one-cycle pulse from reader, data valid.
REQ-013 rd_data  in  8  flash byte, valid with rd_done.
REQ-014 sample  out  8  unsigned PWM duty value.
REQ-015 sample_valid  out  1  one-cycle pulse when sample updates.
REQ-016 busy  out  1  high in any state except IDLE.
REQ-017 done  out  1  one-cycle pulse at non-looping clip end.
REQ-018 underrun  out  1  sticky flag: sample tick arrived while fetch pending.

Function
REQ-019 FSM states: IDLE, WAIT_TICK, FETCH, DRAIN.
REQ-020 IDLE + play + end_addr>=start_addr + no stop: latch bounds, addr<=start_addr, clear tick counter and underrun, go WAIT_TICK; play with end_addr<start_addr is ignored.
REQ-021 Tick counter counts 0..SAMPLE_DIV-1 in every non-IDLE state; tick = terminal count; counter holds while pause high.
REQ-022 WAIT_TICK + tick: rd_req<=1, rd_addr<=addr, go FETCH next cycle.
REQ-023 FETCH: rd_req held high until rd_done; rd_req low the cycle after rd_done.
REQ-024 FETCH + rd_done: sample<=rd_data, sample_valid pulse next cycle (latency 1 clk from rd_done).
REQ-025 On that rd_done, addr!=end: addr<=addr+1, go WAIT_TICK.
REQ-026 On that rd_done, addr==end and loop_en: addr<=start_addr, go WAIT_TICK.
REQ-027 On that rd_done, addr==end and !loop_en: done pulse, sample<=8'h80, go IDLE.
REQ-028 Tick while in FETCH: underrun<=1; tick is not queued; the next fetch waits for the following tick.
REQ-029 Address compare precedes increment; end_addr=all-ones never wraps to 0.
REQ-030 stop in WAIT_TICK: sample<=8'h80, go IDLE.
REQ-031 stop in FETCH: go DRAIN; rd_req stays high until rd_done; rd_data discarded; then sample<=8'h80, IDLE.
REQ-032 stop and play in the same cycle: stop wins; play in any non-IDLE state ignored.
REQ-033 rd_done in IDLE or WAIT_TICK ignored.
REQ-034 pause does not abort an in-flight FETCH; sample holds its value.

Reset
REQ-035 rst_n low: state IDLE, rd_req 0, rd_addr 0, sample 8'h80, sample_valid 0, busy 0, done 0, underrun 0, tick counter 0.
REQ-036 Reset mid-FETCH abandons the request immediately; reader resynchronisation is the reader's duty.

Structure
REQ-037 Package audio_pkg: ADDR_W default, SILENCE=8'h80, FSM state encoding.
REQ-038 Sub-module sample_rate_tick: parameterised divider with enable (= !pause && busy) and synchronous clear, one-cycle tick output.

Verification
REQ-039 SAMPLE_DIV=8, play start=0x10 end=0x12, reader responds in 3 clk with 0xA0/0xA1/0xA2 -> three sample_valid 8 clk apart, rd_addr 0x10,0x11,0x12, done once, sample returns 0x80.
REQ-040 Same clip, loop_en=1 -> rd_addr sequence 0x10,0x11,0x12,0x10...; no done; stop mid-WAIT_TICK -> IDLE next cycle, sample 0x80.
REQ-041 Reader latency 12 clk with SAMPLE_DIV=8 -> underrun=1; cleared by next accepted play.
REQ-042 stop during FETCH -> rd_req held until rd_done, sample stays old value then 0x80, busy low one cycle after rd_done.
REQ-043 end=0xFFFFFF start=0xFFFFFE -> two reads, done, no read of address 0; end<start play -> busy stays 0.
REQ-044 rst_n pulsed low mid-FETCH -> all outputs at reset values asynchronously; pause high 20 clk -> no rd_req issued.

Source files
------------

// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared constants and FSM encoding for the audio playback controller
package audio_pkg;

   localparam int ADDR_W_DEF = 24;
   localparam logic [7:0] SILENCE = 8'h80;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_TICK = 2'd1,
      ST_FETCH     = 2'd2,
      ST_DRAIN     = 2'd3
   } state_e;

endpackage

// File: rtl/sample_rate_tick.sv
// rtl/sample_rate_tick.sv - enabled clock divider producing a one-cycle sample tick
module sample_rate_tick #(
   parameter int DIV = 12500
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en_i,
   input  logic clr_i,
   output logic tick_o
);

   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             at_last;

   assign at_last = (cnt_q == LAST);
   assign tick_o  = en_i && at_last;

   // Count 0..DIV-1 while enabled; clear wins over counting.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = at_last ? '0 : cnt_q + CNT_W'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/audio_playback_controller.sv
// rtl/audio_playback_controller.sv - paces flash byte reads into an 8-bit PWM sample stream
module audio_playback_controller
   import audio_pkg::*;
#(
   parameter int SAMPLE_DIV = 12500,
   parameter int ADDR_W     = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              play,
   input  logic              stop,
   input  logic              pause,
   input  logic              loop_en,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W-1:0] end_addr,
   output logic              rd_req,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic              rd_done,
   input  logic [7:0]        rd_data,
   output logic [7:0]        sample,
   output logic              sample_valid,
   output logic              busy,
   output logic              done,
   output logic              underrun
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] start_q, start_d;
   logic [ADDR_W-1:0] end_q, end_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic              rd_req_q, rd_req_d;
   logic [7:0]        sample_q, sample_d;
   logic              sample_valid_q, sample_valid_d;
   logic              done_q, done_d;
   logic              underrun_q, underrun_d;
   logic              tick;

   assign busy         = (state_q != ST_IDLE);
   assign rd_req       = rd_req_q;
   assign rd_addr      = rd_addr_q;
   assign sample       = sample_q;
   assign sample_valid = sample_valid_q;
   assign done         = done_q;
   assign underrun     = underrun_q;

   // Idle holds the divider at zero so every accepted play starts a fresh sample period.
   sample_rate_tick #(
      .DIV (SAMPLE_DIV)
   ) u_tick (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (busy && !pause),
      .clr_i  (state_q == ST_IDLE),
      .tick_o (tick)
   );

   // Next-state and output decisions; stop always outranks play, tick and rd_done.
   always_comb begin
      state_d        = state_q;
      addr_d         = addr_q;
      start_d        = start_q;
      end_d          = end_q;
      rd_addr_d      = rd_addr_q;
      rd_req_d       = rd_req_q;
      sample_d       = sample_q;
      sample_valid_d = 1'b0;
      done_d         = 1'b0;
      underrun_d     = underrun_q;
      case (state_q)
         ST_IDLE: begin
            if (play && !stop && (end_addr >= start_addr)) begin
               start_d    = start_addr;
               end_d      = end_addr;
               addr_d     = start_addr;
               underrun_d = 1'b0;
               state_d    = ST_WAIT_TICK;
            end
         end
         ST_WAIT_TICK: begin
            if (stop) begin
               sample_d = SILENCE;
               state_d  = ST_IDLE;
            end else if (tick) begin
               rd_req_d  = 1'b1;
               rd_addr_d = addr_q;
               state_d   = ST_FETCH;
            end
         end
         ST_FETCH: begin
            // A tick here is lost, not queued; the next fetch waits for the following tick.
            if (tick) begin
               underrun_d = 1'b1;
            end
            if (stop) begin
               if (rd_done) begin
                  rd_req_d = 1'b0;
                  sample_d = SILENCE;
                  state_d  = ST_IDLE;
               end else begin
                  state_d = ST_DRAIN;
               end
            end else if (rd_done) begin
               rd_req_d       = 1'b0;
               sample_d       = rd_data;
               sample_valid_d = 1'b1;
               // Compare before incrementing so an all-ones end address never wraps.
               if (addr_q != end_q) begin
                  addr_d  = addr_q + ADDR_W'(1);
                  state_d = ST_WAIT_TICK;
               end else if (loop_en) begin
                  addr_d  = start_q;
                  state_d = ST_WAIT_TICK;
               end else begin
                  sample_d = SILENCE;
                  done_d   = 1'b1;
                  state_d  = ST_IDLE;
               end
            end
         end
         ST_DRAIN: begin
            // Keep the request up until the reader answers, then drop its data.
            if (rd_done) begin
               rd_req_d = 1'b0;
               sample_d = SILENCE;
               state_d  = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         addr_q         <= '0;
         start_q        <= '0;
         end_q          <= '0;
         rd_addr_q      <= '0;
         rd_req_q       <= 1'b0;
         sample_q       <= SILENCE;
         sample_valid_q <= 1'b0;
         done_q         <= 1'b0;
         underrun_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         addr_q         <= addr_d;
         start_q        <= start_d;
         end_q          <= end_d;
         rd_addr_q      <= rd_addr_d;
         rd_req_q       <= rd_req_d;
         sample_q       <= sample_d;
         sample_valid_q <= sample_valid_d;
         done_q         <= done_d;
         underrun_q     <= underrun_d;
      end
   end

endmodule
